complete_arb: RTL and testbench
===============================

# complete_arb

Completion-stage arbiter between the functional units (fu_alu, fu_mult, fu_ls, fu_branch) and the common data bus (CDB). Each cycle it selects up to CDB_W of the FUs asserting want_to_complete and latches their FU_COMPLETE_PACKETs into the CDB output register. Every losing FU receives complete_stall in the same cycle so that it holds its result. The registered CDB feeds RS wakeup, the map table, and ROB completion.

## Interface
- NUM_FU, 8: number of FU completion requesters (2..16).
- CDB_W, 2: CDB broadcast slots per cycle (1..NUM_FU).
- clock  in  1: system clock; all state changes on the rising edge.
- reset  in  1: asynchronous, active-low; clears all state immediately.
- squash  in  1: branch-mispredict flush; synchronous.
- fu_want  in  NUM_FU: per-FU want_to_complete.
- fu_pkt  in  NUM_FU x FU_COMPLETE_PACKET: per-FU result (valid, dest_pr, rob_entry, dest_value).
- complete_stall  out  NUM_FU: combinational; FU i must hold its result this cycle.
- cdb_pkt  out  CDB_W x CDB_PACKET: registered broadcast (valid, dest_pr, rob_entry, dest_value).
- rr_ptr  out  $clog2(NUM_FU): current highest-priority index; visibility only.

## Operation
- Grant: scan FUs circularly, starting at rr_ptr. The first CDB_W indices with fu_want=1 are granted, in scan order, to slots 0..CDB_W-1.
- complete_stall[i] = fu_want[i] & ~grant[i]. A non-requesting FU is never stalled.
- Granted packets are copied into cdb_pkt[slot] with valid=1 on the next edge. Unused slots load valid=0; their other fields are don't-care but are driven to 0.
- rr_ptr update: if at least one grant occurs, rr_ptr becomes (index of the last granted FU + 1) mod NUM_FU. Otherwise rr_ptr is unchanged.
- squash=1: all cdb_pkt valid bits are cleared on the next edge. No grants are registered that cycle, complete_stall is forced to 0 (the FUs flush themselves), and rr_ptr is held.
- A request with fu_want=1 and fu_pkt.valid=0 is a protocol error. It is still granted and forwarded as valid=0; an assertion flags it.
- The arbiter holds no per-FU state. A stalled FU re-requests the next cycle with an unchanged packet.

## Timing
- Reset values: cdb_pkt all fields 0 (valid=0), rr_ptr=0. complete_stall follows its inputs, so it is 0 when no FU wants to complete.
- Latency: a grant in cycle t makes the packet visible on cdb_pkt in cycle t+1, exactly one cycle.
- complete_stall has no register stage. The FU samples it at the same edge that captures the grant.
- Throughput: CDB_W completions per cycle, sustained.
- Wrap-around: the scan goes from NUM_FU-1 back to 0. rr_ptr wraps modulo NUM_FU, and non-power-of-two NUM_FU is supported.
- Fairness: with round-robin enabled, any continuously requesting FU is granted within ceil(NUM_FU/CDB_W) cycles.
- Asynchronous reset in the middle of a grant clears cdb_pkt and rr_ptr without waiting for a clock edge.

## Configuration
- COMPLETE_ARB_RR_EN defined: rotating priority as described above.
- COMPLETE_ARB_RR_EN undefined: fixed priority, with index 0 highest. rr_ptr is tied to 0 and has no register.

## Structure
- Shared package: CDB_PACKET typedef, plus NUM_FU and CDB_W defaults (for example NUM_FU_TOTAL and CDB_WIDTH in sys_defs).
- Sub-module: rr_select, a combinational circular multi-grant picker. Inputs are the request vector, start index, and CDB_W. Outputs are the grant vector, per-slot index, and last index.
- complete_arb instantiates rr_select, the cdb_pkt register, and the rr_ptr register.

## Test plan
- Reset deasserted, then fu_want=0 for 3 cycles -> cdb_pkt all valid=0, complete_stall=0, rr_ptr=0.
- Only the mult FU (index 3) requests with dest_value=35, dest_pr=1, rob_entry=2 -> complete_stall[3]=0, and the next cycle cdb_pkt[0] = {1,1,2,35}, cdb_pkt[1].valid=0, rr_ptr=4.
- FUs 0, 3, 5 request with rr_ptr=0 and CDB_W=2 -> grants go to 0 and 3, complete_stall[5]=1, rr_ptr=4. The next cycle FU 5 is granted to slot 0.
- All 8 FUs request continuously for 4 cycles -> grant pairs (0,1), (2,3), (4,5), (6,7). rr_ptr sequence is 2, 4, 6, 0.
- FU 7 and FU 1 request with rr_ptr=6 -> slot 0 gets FU 7, slot 1 gets FU 1, rr_ptr=2 (wrap).
- squash asserted with 2 requests pending -> the next cycle all cdb valid=0, complete_stall=0, rr_ptr unchanged. Async reset mid-stream -> outputs are 0 before the next edge.

Source files
------------

// File: rtl/complete_arb_pkg.sv
// Shared types and defaults for the completion-stage arbiter.
// Packet layouts and FU/CDB sizing used across the pipeline.
package complete_arb_pkg;

    localparam int NUM_FU_TOTAL = 8;
    localparam int CDB_WIDTH    = 2;
    localparam int PR_W         = 6;
    localparam int ROB_W        = 5;
    localparam int VAL_W        = 32;

    typedef struct packed {
        logic             valid;
        logic [PR_W-1:0]  dest_pr;
        logic [ROB_W-1:0] rob_entry;
        logic [VAL_W-1:0] dest_value;
    } fu_complete_packet_t;

    typedef struct packed {
        logic             valid;
        logic [PR_W-1:0]  dest_pr;
        logic [ROB_W-1:0] rob_entry;
        logic [VAL_W-1:0] dest_value;
    } cdb_packet_t;

    function automatic cdb_packet_t to_cdb(input fu_complete_packet_t p);
        cdb_packet_t c;
        c.valid      = p.valid;
        c.dest_pr    = p.dest_pr;
        c.rob_entry  = p.rob_entry;
        c.dest_value = p.dest_value;
        return c;
    endfunction

endpackage

// File: rtl/complete_arb_rr_select.sv
// Circular multi-grant picker: scans from start, grants the first W
// requesters in scan order and reports per-slot and last index.
module rr_select #(
    parameter int N  = 8,
    parameter int W  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]         req,
    input  logic [IW-1:0]        start,
    output logic [N-1:0]         grant,
    output logic [W-1:0][IW-1:0] slot_idx,
    output logic [W-1:0]         slot_vld,
    output logic [IW-1:0]        last_idx
);

    localparam logic [IW:0] NN = (IW+1)'(N);

    logic [IW:0] pos;
    int          cnt;

    // walk indices start, start+1, ... modulo N and fill slots in order
    always_comb begin
        grant    = '0;
        slot_idx = '0;
        slot_vld = '0;
        last_idx = '0;
        cnt      = 0;
        pos      = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, start} + (IW+1)'(k);
            if (pos >= NN) pos = pos - NN;
            if (req[pos[IW-1:0]] && cnt < W) begin
                grant[pos[IW-1:0]] = 1'b1;
                for (int s = 0; s < W; s++) begin
                    if (s == cnt) begin
                        slot_idx[s] = pos[IW-1:0];
                        slot_vld[s] = 1'b1;
                    end
                end
                last_idx = pos[IW-1:0];
                cnt++;
            end
        end
    end

endmodule

// File: rtl/complete_arb.sv
// FU-to-CDB completion arbiter with registered broadcast slots.
// Define COMPLETE_ARB_RR_EN for rotating priority; default is fixed (FU 0 first).
import complete_arb_pkg::*;

module complete_arb #(
    parameter int NUM_FU = NUM_FU_TOTAL,
    parameter int CDB_W  = CDB_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               squash,
    input  logic [NUM_FU-1:0]                  fu_want,
    input  fu_complete_packet_t [NUM_FU-1:0]   fu_pkt,
    output logic [NUM_FU-1:0]                  complete_stall,
    output cdb_packet_t [CDB_W-1:0]            cdb_pkt,
    output logic [$clog2(NUM_FU)-1:0]          rr_ptr
);

    localparam int IW = $clog2(NUM_FU);

    logic [NUM_FU-1:0]          grant;
    logic [CDB_W-1:0][IW-1:0]   slot_idx;
    logic [CDB_W-1:0]           slot_vld;
    logic [IW-1:0]              last_idx;
    cdb_packet_t [CDB_W-1:0]    cdb_d;
    logic [NUM_FU-1:0]          pkt_vld;

    rr_select #(
        .N  (NUM_FU),
        .W  (CDB_W),
        .IW (IW)
    ) u_sel (
        .req      (fu_want),
        .start    (rr_ptr),
        .grant    (grant),
        .slot_idx (slot_idx),
        .slot_vld (slot_vld),
        .last_idx (last_idx)
    );

    // losers hold their result; on squash the FUs flush, so nobody stalls
    assign complete_stall = squash ? '0 : (fu_want & ~grant);

    // gather granted packets into slots; empty or squashed slots are zero
    always_comb begin
        cdb_d = '0;
        for (int s = 0; s < CDB_W; s++) begin
            if (!squash && slot_vld[s]) cdb_d[s] = to_cdb(fu_pkt[slot_idx[s]]);
        end
    end

    // CDB broadcast register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cdb_pkt <= '0;
        else        cdb_pkt <= cdb_d;
    end

`ifdef COMPLETE_ARB_RR_EN
    logic [IW-1:0] rr_q;
    logic [IW-1:0] rr_nxt;

    assign rr_nxt = (last_idx == IW'(NUM_FU-1)) ? '0 : last_idx + 1'b1;

    // advance priority past the last winner; hold when idle or squashed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                 rr_q <= '0;
        else if (!squash && |grant) rr_q <= rr_nxt;
    end

    assign rr_ptr = rr_q;
`else
    logic unused_last;
    assign unused_last = ^last_idx;
    assign rr_ptr      = '0;
`endif

    // per-FU packet valid bits for the protocol check
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) pkt_vld[i] = fu_pkt[i].valid;
    end

    a_want_has_valid: assert property (
        @(posedge clock) disable iff (!reset) ~|(fu_want & ~pkt_vld)
    );

endmodule

// File: tb/tb_complete_arb.sv
// Directed bench for complete_arb (NUM_FU=8, CDB_W=2).
// Expectations follow COMPLETE_ARB_RR_EN: rotating if defined, else fixed.
import complete_arb_pkg::*;

module tb_complete_arb;

`ifdef COMPLETE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                           clock;
    logic                           reset;
    logic                           squash;
    logic [7:0]                     fu_want;
    fu_complete_packet_t [7:0]      fu_pkt;
    logic [7:0]                     complete_stall;
    cdb_packet_t [1:0]              cdb_pkt;
    logic [2:0]                     rr_ptr;

    int n_chk  = 0;
    int n_fail = 0;

    complete_arb #(
        .NUM_FU (8),
        .CDB_W  (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .squash         (squash),
        .fu_want        (fu_want),
        .fu_pkt         (fu_pkt),
        .complete_stall (complete_stall),
        .cdb_pkt        (cdb_pkt),
        .rr_ptr         (rr_ptr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cdb_packet_t exp_pkt(input int i);
        cdb_packet_t c;
        c.valid      = 1'b1;
        c.dest_pr    = PR_W'(i + 10);
        c.rob_entry  = ROB_W'(i + 1);
        c.dest_value = VAL_W'(100 + i);
        return c;
    endfunction

    task automatic set_pkt(input int i);
        fu_pkt[i].valid      = 1'b1;
        fu_pkt[i].dest_pr    = PR_W'(i + 10);
        fu_pkt[i].rob_entry  = ROB_W'(i + 1);
        fu_pkt[i].dest_value = VAL_W'(100 + i);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    cdb_packet_t e3;

    initial begin
        reset   = 1'b0;
        squash  = 1'b0;
        fu_want = '0;
        for (int i = 0; i < 8; i++) set_pkt(i);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cdb0", 64'(cdb_pkt[0]), 64'(0));
        chk("rst_cdb1", 64'(cdb_pkt[1]), 64'(0));
        chk("rst_rr", 64'(rr_ptr), 64'(0));
        reset = 1'b1;

        for (int c = 0; c < 3; c++) begin
            step();
            chk("idle_valid", 64'({cdb_pkt[1].valid, cdb_pkt[0].valid}), 64'(0));
            chk("idle_stall", 64'(complete_stall), 64'(0));
            chk("idle_rr", 64'(rr_ptr), 64'(0));
        end

        // FUs 0,3,5 from rr_ptr 0
        fu_want = 8'h29;
        #1;
        chk("t035_stall", 64'(complete_stall), 64'h20);
        step();
        chk("t035_cdb0", 64'(cdb_pkt[0]), 64'(exp_pkt(0)));
        chk("t035_cdb1", 64'(cdb_pkt[1]), 64'(exp_pkt(3)));
        chk("t035_rr", 64'(rr_ptr), RR ? 64'd4 : 64'd0);

        // FU 5 follows up
        fu_want = 8'h20;
        #1;
        chk("t5_stall", 64'(complete_stall), 64'(0));
        step();
        chk("t5_cdb0", 64'(cdb_pkt[0]), 64'(exp_pkt(5)));
        chk("t5_cdb1", 64'(cdb_pkt[1]), 64'(0));
        chk("t5_rr", 64'(rr_ptr), RR ? 64'd6 : 64'd0);

        // FU 7 and FU 1, wrap from rr_ptr 6
        fu_want = 8'h82;
        #1;
        chk("t71_stall", 64'(complete_stall), 64'(0));
        step();
        chk("t71_cdb0", 64'(cdb_pkt[0]), RR ? 64'(exp_pkt(7)) : 64'(exp_pkt(1)));
        chk("t71_cdb1", 64'(cdb_pkt[1]), RR ? 64'(exp_pkt(1)) : 64'(exp_pkt(7)));
        chk("t71_rr", 64'(rr_ptr), RR ? 64'd2 : 64'd0);

        // mult FU alone with a specific packet
        fu_pkt[3].valid      = 1'b1;
        fu_pkt[3].dest_pr    = PR_W'(1);
        fu_pkt[3].rob_entry  = ROB_W'(2);
        fu_pkt[3].dest_value = VAL_W'(35);
        e3.valid      = 1'b1;
        e3.dest_pr    = PR_W'(1);
        e3.rob_entry  = ROB_W'(2);
        e3.dest_value = VAL_W'(35);
        fu_want = 8'h08;
        #1;
        chk("t3_stall", 64'(complete_stall[3]), 64'(0));
        step();
        chk("t3_cdb0", 64'(cdb_pkt[0]), 64'(e3));
        chk("t3_cdb1_v", 64'(cdb_pkt[1].valid), 64'(0));
        chk("t3_rr", 64'(rr_ptr), RR ? 64'd4 : 64'd0);
        set_pkt(3);

        // squash with three requests pending
        fu_want = 8'h15;
        squash  = 1'b1;
        #1;
        chk("sq_stall", 64'(complete_stall), 64'(0));
        step();
        chk("sq_valid", 64'({cdb_pkt[1].valid, cdb_pkt[0].valid}), 64'(0));
        chk("sq_rr", 64'(rr_ptr), RR ? 64'd4 : 64'd0);
        squash = 1'b0;

        // FU 7 alone brings rr_ptr back to 0
        fu_want = 8'h80;
        step();
        chk("t7_cdb0", 64'(cdb_pkt[0]), 64'(exp_pkt(7)));
        chk("t7_rr", 64'(rr_ptr), 64'(0));

        // all FUs request for four cycles
        fu_want = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("all_stall", 64'(complete_stall),
                RR ? 64'(~(8'h03 << (2 * c))) : 64'hFC);
            step();
            chk("all_cdb0", 64'(cdb_pkt[0]),
                RR ? 64'(exp_pkt(2 * c)) : 64'(exp_pkt(0)));
            chk("all_cdb1", 64'(cdb_pkt[1]),
                RR ? 64'(exp_pkt(2 * c + 1)) : 64'(exp_pkt(1)));
            chk("all_rr", 64'(rr_ptr), RR ? 64'((2 * c + 2) % 8) : 64'd0);
        end

        // load the CDB then pull reset between edges
        fu_want = 8'h06;
        step();
        chk("pre_cdb0", 64'(cdb_pkt[0]), 64'(exp_pkt(1)));
        chk("pre_rr", 64'(rr_ptr), RR ? 64'd3 : 64'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cdb0", 64'(cdb_pkt[0]), 64'(0));
        chk("arst_cdb1", 64'(cdb_pkt[1]), 64'(0));
        chk("arst_rr", 64'(rr_ptr), 64'(0));
        fu_want = '0;
        step();
        reset = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
